// File: rtl/edubos5_pkg.sv
// Shared eduBOS5 types: ALU funct3 encodings, ALU FSM states, bit-reverse helper.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package edubos5_pkg;

  typedef enum logic [2:0] {
    ADD_SUB = 3'b000,
    SLL     = 3'b001,
    SLT     = 3'b010,
    SLTU    = 3'b011,
    XOR     = 3'b100,
    SRL_SRA = 3'b101,
    OR      = 3'b110,
    AND     = 3'b111
  } funct3_alu_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_t;

  localparam int unsigned FLIP_MAX = 64;

  // Reverse the low w bits of v (w <= FLIP_MAX); bits above w come back zero.
  // Full reversal puts bit j at FLIP_MAX-1-j, the right shift moves it to w-1-j.
  function automatic logic [FLIP_MAX-1:0] flip(input logic [FLIP_MAX-1:0] v,
                                               input int unsigned w);
    logic [FLIP_MAX-1:0] r;
    for (int i = 0; i < FLIP_MAX; i++) r[i] = v[FLIP_MAX-1-i];
    return r >> (FLIP_MAX - w);
  endfunction

endpackage

// File: rtl/edubos5_alu_shifter.sv
// One right-shift step of 0..SHIFT_STEP bits with a programmable fill bit.
// Latency: combinational; becomes the full barrel shifter when SHIFT_STEP == XLEN.
// Backpressure: none, pure function of its inputs.
module edubos5_alu_shifter #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4,
  parameter int AW         = $clog2(SHIFT_STEP + 1)
) (
  input  logic [XLEN-1:0] din_i,
  input  logic [AW-1:0]   amt_i,
  input  logic            fill_i,
  output logic [XLEN-1:0] dout_o
);

  logic [2*XLEN-1:0] ext;

  // Fill bits sit above the operand so they slide in from the top
  assign ext    = {{XLEN{fill_i}}, din_i};
  assign dout_o = XLEN'(ext >> amt_i);

endmodule

// File: rtl/edubos5_alu_mc.sv
// Multi-cycle RV32I/RV64I integer ALU with serial (SHIFT_STEP bits/cycle) or barrel shifts.
// Latency: 1 cycle, serial shifts max(1, ceil(shamt/SHIFT_STEP)) cycles; out_valid is a 1-cycle pulse.
// Backpressure: in_ready low while a serial shift is in flight; no output stall, flush squashes.
module edubos5_alu_mc
  import edubos5_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         aluin_1,
  input  logic [XLEN-1:0]         aluin_2,
  input  logic [$clog2(XLEN)-1:0] shamt,
  input  funct3_alu_t             funct3,
  input  logic                    funct7_5,
  input  logic                    aluimm_dec,
  input  logic                    jalr_dec,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [XLEN-1:0]         alu_out,
  output logic                    eq,
  output logic                    ltu,
  output logic                    lt,
  output logic                    busy
);

  localparam int SAW = $clog2(XLEN);
  localparam int AW  = $clog2(SHIFT_STEP + 1);
  localparam logic [SAW:0] STEP_C = (SAW+1)'(SHIFT_STEP);

  alu_state_t      state_q, state_d;
  logic [SAW-1:0]  rem_q, rem_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic            fill_q, fill_d, sll_q, sll_d;
  logic            peq_q, peq_d, pltu_q, pltu_d, plt_q, plt_d;
  logic            vld_q, vld_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            eq_q, eq_d, ltu_q, ltu_d, lt_q, lt_d;

  logic            idle, accept, is_shift, is_sub, new_sll, new_fill;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] sum;
  logic            f_eq, f_ltu, f_lt;
  logic [XLEN-1:0] sh_in, sh_out, shift_res, op_res;
  logic            fill_in, sll_flag;
  logic [SAW:0]    cur, step;
  logic [AW-1:0]   amt;
  logic [SAW-1:0]  rem_nxt;

  assign idle     = (state_q == IDLE);
  assign in_ready = idle & reset;
  assign accept   = in_valid & in_ready & ~flush;
  assign busy     = (state_q == SHIFT);

  assign out_valid = vld_q;
  assign alu_out   = res_q;
  assign eq        = eq_q;
  assign ltu       = ltu_q;
  assign lt        = lt_q;

  // Arithmetic, flags and the operand/amount fed to this cycle's shift step
  always_comb begin
    is_shift = (funct3 == SLL) || (funct3 == SRL_SRA);
    is_sub   = (funct3 == ADD_SUB) & funct7_5 & ~aluimm_dec & ~jalr_dec;
    diff     = {1'b0, aluin_1} + {1'b1, ~aluin_2} + (XLEN+1)'(1);
    sum      = aluin_1 + aluin_2;
    f_eq     = (diff[XLEN-1:0] == '0);
    f_ltu    = diff[XLEN];
    f_lt     = (aluin_1[XLEN-1] ^ aluin_2[XLEN-1]) ? aluin_1[XLEN-1] : diff[XLEN];
    new_sll  = (funct3 == SLL);
    new_fill = (funct3 == SRL_SRA) & funct7_5 & aluin_1[XLEN-1];
    // A fresh op comes from the input ports, an in-flight one from the work register
    sh_in    = idle ? (new_sll ? XLEN'(flip(64'(aluin_1), XLEN)) : aluin_1) : sh_q;
    fill_in  = idle ? new_fill : fill_q;
    cur      = idle ? {1'b0, shamt} : {1'b0, rem_q};
    step     = (cur > STEP_C) ? STEP_C : cur;
    amt      = AW'(step);
    rem_nxt  = SAW'(cur - step);
  end

  edubos5_alu_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP),
    .AW         (AW)
  ) u_shifter (
    .din_i  (sh_in),
    .amt_i  (amt),
    .fill_i (fill_in),
    .dout_o (sh_out)
  );

  // Result mux; SLL is undone by flipping the right-shifted value back
  always_comb begin
    sll_flag  = idle ? new_sll : sll_q;
    shift_res = sll_flag ? XLEN'(flip(64'(sh_out), XLEN)) : sh_out;
    case (funct3)
      ADD_SUB: op_res = is_sub ? diff[XLEN-1:0] : sum;
      SLT:     op_res = XLEN'(f_lt);
      SLTU:    op_res = XLEN'(f_ltu);
      XOR:     op_res = aluin_1 ^ aluin_2;
      OR:      op_res = aluin_1 | aluin_2;
      AND:     op_res = aluin_1 & aluin_2;
      default: op_res = shift_res;
    endcase
  end

  // FSM next state: flush wins, then accept in IDLE, then serial shift progress
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    fill_d  = fill_q;
    sll_d   = sll_q;
    peq_d   = peq_q;
    pltu_d  = pltu_q;
    plt_d   = plt_q;
    vld_d   = 1'b0;
    res_d   = res_q;
    eq_d    = eq_q;
    ltu_d   = ltu_q;
    lt_d    = lt_q;
    if (flush) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (idle) begin
      if (accept) begin
        // Flags are parked so a multi-cycle shift can publish them with its result
        peq_d  = f_eq;
        pltu_d = f_ltu;
        plt_d  = f_lt;
        sh_d   = sh_out;
        fill_d = new_fill;
        sll_d  = new_sll;
        rem_d  = is_shift ? rem_nxt : '0;
        if (!is_shift || (rem_nxt == '0)) begin
          vld_d = 1'b1;
          res_d = op_res;
          eq_d  = f_eq;
          ltu_d = f_ltu;
          lt_d  = f_lt;
        end else begin
          state_d = SHIFT;
        end
      end
    end else begin
      sh_d  = sh_out;
      rem_d = rem_nxt;
      if (rem_nxt == '0) begin
        vld_d   = 1'b1;
        res_d   = shift_res;
        eq_d    = peq_q;
        ltu_d   = pltu_q;
        lt_d    = plt_q;
        state_d = IDLE;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sh_q    <= '0;
      fill_q  <= 1'b0;
      sll_q   <= 1'b0;
      peq_q   <= 1'b0;
      pltu_q  <= 1'b0;
      plt_q   <= 1'b0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      eq_q    <= 1'b0;
      ltu_q   <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      fill_q  <= fill_d;
      sll_q   <= sll_d;
      peq_q   <= peq_d;
      pltu_q  <= pltu_d;
      plt_q   <= plt_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      eq_q    <= eq_d;
      ltu_q   <= ltu_d;
      lt_q    <= lt_d;
    end
  end

endmodule

// File: tb/tb_edubos5_alu_mc.sv
// Directed bench for edubos5_alu_mc (XLEN=32/STEP=4 plus a 64-bit barrel instance).
// Results are predicted by a behavioural model into a scoreboard and popped on out_valid.
// Handshake timing, flush and reset behaviour are checked at fixed cycles.
module tb_edubos5_alu_mc;
  import edubos5_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, funct7_5, aluimm_dec, jalr_dec, flush;
  logic [31:0] aluin_1, aluin_2;
  logic [4:0]  shamt;
  funct3_alu_t funct3;
  logic        in_ready, out_valid, eq, ltu, lt, busy;
  logic [31:0] alu_out;

  logic        w_in_valid, w_f7;
  logic [63:0] w_a, w_b, w_out;
  logic [5:0]  w_shamt;
  funct3_alu_t w_f3;
  logic        w_in_ready, w_out_valid, w_eq, w_ltu, w_lt, w_busy;

  edubos5_alu_mc #(.XLEN(32), .SHIFT_STEP(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aluin_1(aluin_1), .aluin_2(aluin_2), .shamt(shamt), .funct3(funct3),
    .funct7_5(funct7_5), .aluimm_dec(aluimm_dec), .jalr_dec(jalr_dec), .flush(flush),
    .out_valid(out_valid), .alu_out(alu_out), .eq(eq), .ltu(ltu), .lt(lt), .busy(busy)
  );

  edubos5_alu_mc #(.XLEN(64), .SHIFT_STEP(64)) dut_w (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .aluin_1(w_a), .aluin_2(w_b), .shamt(w_shamt), .funct3(w_f3),
    .funct7_5(w_f7), .aluimm_dec(1'b0), .jalr_dec(1'b0), .flush(1'b0),
    .out_valid(w_out_valid), .alu_out(w_out), .eq(w_eq), .ltu(w_ltu), .lt(w_lt), .busy(w_busy)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        eq;
    logic        ltu;
    logic        lt;
  } exp_t;

  exp_t        q[$];
  logic [31:0] last_res = '0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input funct3_alu_t f3, input logic f7, input logic imm,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    exp_t e;
    e.eq  = (a == b);
    e.ltu = (a < b);
    e.lt  = ($signed(a) < $signed(b));
    case (f3)
      ADD_SUB: e.res = (f7 && !imm) ? a - b : a + b;
      SLL:     e.res = a << sh;
      SLT:     e.res = {31'd0, e.lt};
      SLTU:    e.res = {31'd0, e.ltu};
      XOR:     e.res = a ^ b;
      SRL_SRA: e.res = f7 ? 32'($signed(a) >>> sh) : a >> sh;
      OR:      e.res = a | b;
      default: e.res = a & b;
    endcase
    return e;
  endfunction

  task automatic drive(input funct3_alu_t f3, input logic f7, input logic imm,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic push);
    in_valid   = 1'b1;
    funct3     = f3;
    funct7_5   = f7;
    aluimm_dec = imm;
    aluin_1    = a;
    aluin_2    = b;
    shamt      = sh;
    if (push) q.push_back(model(f3, f7, imm, a, b, sh));
  endtask

  task automatic wait_valid(input int maxc, input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (out_valid === 1'b1) else begin
      bad++;
      $error("FAIL %s timeout observed=%0d expected=1", tag, out_valid);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the oldest predicted result
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      check("sb_pending", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("sb_res", 64'(alu_out), 64'(e.res));
        check("sb_eq", 64'(eq), 64'(e.eq));
        check("sb_ltu", 64'(ltu), 64'(e.ltu));
        check("sb_lt", 64'(lt), 64'(e.lt));
        last_res = e.res;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; funct3 = ADD_SUB; funct7_5 = 1'b0;
    aluimm_dec = 1'b0; jalr_dec = 1'b0; aluin_1 = '0; aluin_2 = '0; shamt = '0;
    w_in_valid = 1'b0; w_f3 = ADD_SUB; w_f7 = 1'b0; w_a = '0; w_b = '0; w_shamt = '0;

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(alu_out), 64'd0);
    check("rst_flags", 64'({eq, ltu, lt}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_ready_w", 64'(w_in_ready), 64'd0);
    reset = 1'b1;
    #1 check("rel_ready", 64'(in_ready), 64'd1);

    // Single-cycle ops, issued back to back
    @(negedge clk);
    drive(ADD_SUB, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1);
    @(negedge clk); check("add_lat", 64'(out_valid), 64'd1);
    drive(ADD_SUB, 1'b1, 1'b0, 32'd5, 32'd7, 5'd0, 1'b1);
    @(negedge clk); check("sub_lat", 64'(out_valid), 64'd1);
    drive(SLT, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1);
    @(negedge clk); check("slt_lat", 64'(out_valid), 64'd1);
    drive(SLTU, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1);
    @(negedge clk);
    drive(XOR, 1'b0, 1'b0, 32'h1234, 32'h1234, 5'd0, 1'b1);
    @(negedge clk);
    drive(ADD_SUB, 1'b1, 1'b1, 32'd10, 32'd3, 5'd0, 1'b1);
    @(negedge clk);
    drive(ADD_SUB, 1'b0, 1'b0, 32'hA5A5_0000, 32'h0000_5A5A, 5'd0, 1'b1);
    @(negedge clk); check("b2b_add", 64'(out_valid), 64'd1);
    drive(XOR, 1'b0, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 1'b1);
    @(negedge clk); check("b2b_xor", 64'(out_valid), 64'd1);
    drive(AND, 1'b0, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 1'b1);
    @(negedge clk); check("b2b_and", 64'(out_valid), 64'd1);
    drive(OR, 1'b0, 1'b0, 32'h8000_0001, 32'h0000_0100, 5'd0, 1'b1);
    @(negedge clk); check("or_lat", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    @(negedge clk); check("idle_quiet", 64'(out_valid), 64'd0);

    // Serial SRA by 31: 8 steps of at most 4 bits
    drive(SRL_SRA, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 5'd31, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("sra_ready%0d", k), 64'(in_ready), 64'd0);
      check($sformatf("sra_busy%0d", k), 64'(busy), 64'd1);
      check($sformatf("sra_novld%0d", k), 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    check("sra_vld8", 64'(out_valid), 64'd1);
    check("sra_ready8", 64'(in_ready), 64'd1);
    check("sra_busy8", 64'(busy), 64'd0);

    drive(SLL, 1'b0, 1'b0, 32'd1, 32'd0, 5'd31, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    wait_valid(10, "sll31");
    @(negedge clk);
    drive(SRL_SRA, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0, 5'd0, 1'b1);
    @(negedge clk); check("sh0_lat", 64'(out_valid), 64'd1);
    drive(SRL_SRA, 1'b0, 1'b0, 32'hF000_000F, 32'd0, 5'd4, 1'b1);
    @(negedge clk); check("sh4_lat", 64'(out_valid), 64'd1);
    drive(SRL_SRA, 1'b1, 1'b0, 32'h9000_0000, 32'd0, 5'd5, 1'b1);
    @(negedge clk); in_valid = 1'b0; check("sh5_c1", 64'(out_valid), 64'd0);
    @(negedge clk); check("sh5_c2", 64'(out_valid), 64'd1);

    // Flush three cycles into an SRL by 20
    @(negedge clk);
    drive(SRL_SRA, 1'b0, 1'b0, 32'hFFFF_0000, 32'd0, 5'd20, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("fl_novld", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready), 64'd1);
    check("fl_busy", 64'(busy), 64'd0);
    check("fl_hold", 64'(alu_out), 64'(last_res));
    @(negedge clk); check("fl_quiet", 64'(out_valid), 64'd0);
    drive(ADD_SUB, 1'b0, 1'b0, 32'd2, 32'd3, 5'd0, 1'b1);
    @(negedge clk); in_valid = 1'b0; check("fl_add", 64'(out_valid), 64'd1);

    // Flush coincident with in_valid: nothing accepted
    @(negedge clk);
    drive(ADD_SUB, 1'b0, 1'b0, 32'd9, 32'd9, 5'd0, 1'b0);
    flush = 1'b1;
    @(negedge clk); in_valid = 1'b0; flush = 1'b0;
    check("flc_novld", 64'(out_valid), 64'd0);
    check("flc_busy", 64'(busy), 64'd0);
    @(negedge clk); check("flc_quiet", 64'(out_valid), 64'd0);

    // Reset mid-shift discards the op
    drive(SRL_SRA, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 5'd31, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_out", 64'(alu_out), 64'd0);
    check("mrst_flags", 64'({eq, ltu, lt}), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    #1 check("mrst_rel", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(ADD_SUB, 1'b0, 1'b0, 32'd100, 32'd23, 5'd0, 1'b1);
    @(negedge clk); in_valid = 1'b0; check("mrst_add", 64'(out_valid), 64'd1);

    // 64-bit barrel instance: single-cycle shifts
    @(negedge clk);
    w_in_valid = 1'b1; w_f3 = SRL_SRA; w_f7 = 1'b1;
    w_a = 64'h8000_0000_0000_0000; w_b = 64'd0; w_shamt = 6'd63;
    @(negedge clk);
    check("w_sra_vld", 64'(w_out_valid), 64'd1);
    check("w_sra_res", w_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("w_sra_busy", 64'(w_busy), 64'd0);
    check("w_sra_ready", 64'(w_in_ready), 64'd1);
    check("w_sra_flags", 64'({w_eq, w_ltu, w_lt}), 64'b001);
    w_f7 = 1'b0;
    @(negedge clk); check("w_srl_res", w_out, 64'd1);
    w_f3 = SLL; w_f7 = 1'b1; w_a = 64'h8000_0000_0000_0001; w_shamt = 6'd1;
    @(negedge clk); check("w_sll_res", w_out, 64'd2);
    w_a = 64'd1; w_shamt = 6'd63;
    @(negedge clk); check("w_sll63", w_out, 64'h8000_0000_0000_0000);
    w_in_valid = 1'b0;
    @(negedge clk); check("w_quiet", 64'(w_out_valid), 64'd0);

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
